// File: rtl/matrix_mul_seq_ctrl.sv
// matrix_mul_seq_ctrl: streams in complex matrices A and B, then emits A*B one element at a time
module matrix_mul_seq_ctrl #(
  parameter int A_N   = 2,
  parameter int A_M   = 2,
  parameter int B_N   = 2,
  parameter int B_M   = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_last,
  output logic             busy
);
  localparam int A_SZ   = A_N * A_M;
  localparam int B_SZ   = B_N * B_M;
  localparam int LD_MAX = A_SZ > B_SZ ? A_SZ : B_SZ;
  localparam int LW     = $clog2(LD_MAX + 1);
  localparam int AIW    = A_SZ > 1 ? $clog2(A_SZ) : 1;
  localparam int BIW    = B_SZ > 1 ? $clog2(B_SZ) : 1;
  localparam int KW     = $clog2(A_M + 1);
  localparam int IW     = $clog2(A_N + 1);
  localparam int JW     = $clog2(B_M + 1);
  localparam int AW     = 2 * WIDTH + $clog2(A_M) + 1;
  localparam int FB     = WIDTH / 2;

  generate
    if (A_M != B_N) begin : g_dim_err
      $error("matrix_mul_seq_ctrl: A_M must equal B_N");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD_A, LOAD_B, CALC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           ld_q, ld_d;
  logic [KW-1:0]           k_q, k_d;
  logic [IW-1:0]           i_q, i_d;
  logic [JW-1:0]           j_q, j_d;
  logic signed [AW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [WIDTH-1:0]        out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [WIDTH-1:0] a_re [A_SZ];
  logic signed [WIDTH-1:0] a_im [A_SZ];
  logic signed [WIDTH-1:0] b_re [B_SZ];
  logic signed [WIDTH-1:0] b_im [B_SZ];
  logic [AIW-1:0]          a_idx;
  logic [BIW-1:0]          b_idx;
  logic signed [WIDTH-1:0] ar, ai, br, bi;
  logic signed [2*WIDTH-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [AW-1:0]    p_re, p_im;
  logic                    in_fire, out_fire, ld_a_done, ld_b_done, k_done, res_last, a_we, b_we;

  // state and datapath registers, async reset back to an empty LOAD_A
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_A;
      ld_q     <= '0;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

  // matrix storage, written only on accepted input transfers
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_re[ld_q[AIW-1:0]] <= in_re;
      a_im[ld_q[AIW-1:0]] <= in_im;
    end
    if (b_we) begin
      b_re[ld_q[BIW-1:0]] <= in_re;
      b_im[ld_q[BIW-1:0]] <= in_im;
    end
  end

  // handshake and sequencing conditions
  always_comb begin
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    ld_a_done = ld_q == LW'(A_SZ - 1);
    ld_b_done = ld_q == LW'(B_SZ - 1);
    k_done    = k_q == KW'(A_M - 1);
    res_last  = (i_q == IW'(A_N - 1)) && (j_q == JW'(B_M - 1));
    a_we      = in_fire && state_q == LOAD_A;
    b_we      = in_fire && state_q == LOAD_B;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (in_fire && ld_a_done) state_d = LOAD_B;
      LOAD_B:  if (in_fire && ld_b_done) state_d = CALC;
      CALC:    if (k_done) state_d = OUT;
      OUT:     if (out_fire) state_d = res_last ? LOAD_A : CALC;
      default: state_d = LOAD_A;
    endcase
  end

  // one complex MAC per CALC cycle on A[k][i] * B[j][k]
  always_comb begin
    a_idx = AIW'(k_q * A_N + i_q);
    b_idx = BIW'(j_q * B_N + k_q);
    ar    = a_re[a_idx];
    ai    = a_im[a_idx];
    br    = b_re[b_idx];
    bi    = b_im[b_idx];
    m_rr  = ar * br;
    m_ii  = ai * bi;
    m_ri  = ar * bi;
    m_ir  = ai * br;
    p_re  = AW'(m_rr) - AW'(m_ii);
    p_im  = AW'(m_ri) + AW'(m_ir);
  end

  // counters, accumulators and the registered result slice
  always_comb begin
    ld_d     = ld_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    if (in_fire)
      ld_d = ((state_q == LOAD_A) ? ld_a_done : ld_b_done) ? '0 : ld_q + 1'b1;
    if (b_we && ld_b_done) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end
    if (state_q == CALC) begin
      acc_re_d = acc_re_q + p_re;
      acc_im_d = acc_im_q + p_im;
      k_d      = k_done ? '0 : k_q + 1'b1;
      out_re_d = acc_re_d[WIDTH+FB-1:FB];
      out_im_d = acc_im_d[WIDTH+FB-1:FB];
    end
    if (out_fire) begin
      acc_re_d = '0;
      acc_im_d = '0;
      i_d      = (i_q == IW'(A_N - 1)) ? '0 : i_q + 1'b1;
      j_d      = res_last ? '0 : (i_q == IW'(A_N - 1)) ? j_q + 1'b1 : j_q;
    end
  end

  // state-decoded handshakes and status
  always_comb begin
    in_ready  = state_q == LOAD_A || state_q == LOAD_B;
    out_valid = state_q == OUT;
    busy      = state_q == CALC || state_q == OUT;
    out_last  = out_valid && res_last;
    out_re    = out_re_q;
    out_im    = out_im_q;
  end
endmodule

// File: doc/matrix_mul_seq_ctrl.md
MATRIX_MUL_SEQ_CTRL -- requirements
Module: matrix_mul_seq_ctrl

Interface
REQ-001 SHALL have parameter A_N, default 2: element count in one column of matrix A (row count).
REQ-002 SHALL have parameter A_M, default 2: element count in one row of matrix A (column count).
REQ-003 SHALL have parameter B_N, default 2: element count in one column of matrix B.
REQ-004 SHALL have parameter B_M, default 2: element count in one row of matrix B.
REQ-005 SHALL have parameter WIDTH, default 16: signed fixed-point element width, WIDTH/2 fractional bits.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: input element valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts an input element.
REQ-010 SHALL have port in_re, input, WIDTH bits: real part of input element.
REQ-011 SHALL have port in_im, input, WIDTH bits: imaginary part of input element.
REQ-012 SHALL have port out_valid, output, 1 bit: result element valid.
REQ-013 SHALL have port out_ready, input, 1 bit: sink accepts a result element.
REQ-014 SHALL have port out_re, output, WIDTH bits: real part of result element.
REQ-015 SHALL have port out_im, output, WIDTH bits: imaginary part of result element.
REQ-016 SHALL have port out_last, output, 1 bit: high with the final result element.
REQ-017 SHALL have port busy, output, 1 bit: high in CALC and OUT states.

Function
REQ-018 SHALL stop elaboration with an error when A_M != B_N.
REQ-019 SHALL implement states LOAD_A, LOAD_B, CALC, OUT; no other reachable states.
REQ-020 SHALL transfer an element on any edge where valid and ready are both high (input and output independently).
REQ-021 SHALL hold in_ready high only in LOAD_A and LOAD_B; out_valid high only in OUT.
REQ-022 SHALL store A in LOAD_A, column-major: column index m outer (0..A_M-1), row index n inner (0..A_N-1); after A_M*A_N transfers, go to LOAD_B.
REQ-023 SHALL store B in LOAD_B in the same order; after B_M*B_N transfers, go to CALC.
REQ-024 SHALL compute result element res[j][i] = sum over k of A[k][i]*B[j][k], complex: re = ar*br - ai*bi, im = ar*bi + ai*br.
REQ-025 SHALL use one complex multiply-accumulate per clock: CALC lasts exactly A_M cycles per result element; accumulators clear on CALC entry.
REQ-026 SHALL accumulate at full precision: 2*WIDTH + clog2(A_M) + 1 bits signed.
REQ-027 SHALL form each output as accumulator bits [WIDTH+WIDTH/2-1 : WIDTH/2]: truncation toward minus infinity, two's-complement wrap, no saturation.
REQ-028 SHALL raise out_valid exactly A_M cycles after the edge that accepts the last B element.
REQ-029 SHALL hold out_re, out_im and out_last stable while out_valid is high and out_ready is low.
REQ-030 SHALL emit results in order: j outer (0..B_M-1), i inner (0..A_N-1); after each non-final output transfer, re-enter CALC for the next element.
REQ-031 SHALL assert out_last only for res[B_M-1][A_N-1]; its transfer returns the block to LOAD_A with all counters zero.
REQ-032 SHALL ignore in_valid outside the LOAD states; stored matrices are not altered in CALC or OUT.

Reset
REQ-033 SHALL, on rst high, enter LOAD_A immediately, independent of clk.
REQ-034 SHALL clear to zero on reset: all counters, accumulators, out_re, out_im, out_valid, out_last and busy; in_ready is 1.
REQ-035 SHALL discard any partial load or computation on reset mid-operation; the next transfer is A[0][0].

Verification
REQ-036 SHALL pass: 2x2, WIDTH=16, all A and B elements 0x0200+j0x0200, out_ready=1 -> four results re=0x0000, im=0x1000, first out_valid 2 cycles after the last B transfer, out_last on the 4th only.
REQ-037 SHALL pass: A = identity (0x0100 diagonal, zero imaginary), B arbitrary -> outputs equal B in load order.
REQ-038 SHALL pass: out_ready held low 5 cycles in OUT -> out_valid and data stable; no next element until handshake.
REQ-039 SHALL pass: in_valid toggled randomly during load -> only handshaked elements stored; in_ready low from CALC entry.
REQ-040 SHALL pass: rst pulsed after 3 B elements -> in_ready=1, busy=0, then a full reload produces correct results.
REQ-041 SHALL pass: all elements 0x7F00+j0 -> real output wraps per REQ-027 (0x7F00*0x7F00*2 truncated) with no saturation.
